// File: rtl/ifq_pkg.sv
// ifq_pkg: shared definitions for the instruction fetch queue.
//   - Default parameter constants for ifetch_queue.
//   - OP_J: primary opcode of the direct jump (J) instruction, bits [31:26].
//   - ifq_state_e: fetch control states (StBoot, StRun, StFlush).
//   - ifq_entry_t: one queue entry {instr, pcplus4}. pcplus4 is sized for the
//     widest supported XLEN (IFQ_XLEN_MAX); narrower builds zero-extend it.
package ifq_pkg;

  localparam int unsigned IFQ_XLEN_DEFAULT     = 32;
  localparam int unsigned IFQ_QDEPTH_DEFAULT   = 4;
  localparam int unsigned IFQ_RESET_PC_DEFAULT = 0;
  localparam int unsigned IFQ_XLEN_MAX         = 64;

  localparam logic [5:0] OP_J = 6'b000010;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFlush
  } ifq_state_e;

  typedef struct packed {
    logic [31:0]             instr;
    logic [IFQ_XLEN_MAX-1:0] pcplus4;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO of ifq_entry_t with a single-cycle flush.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset; empties the FIFO immediately
//   flush_i  - empties the FIFO at the next edge; overrides push and pop
//   push_i   - write wdata_i (ignored when full and not popping)
//   wdata_i  - entry to write
//   pop_i    - drop the head entry (ignored when empty)
//   head_o   - head entry, all-zero while empty
//   count_o  - occupancy, $clog2(Depth)+1 bits
// Depth must be a power of two so the pointers wrap naturally.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned Depth = IFQ_QDEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  ifq_entry_t               wdata_i,
  input  logic                     pop_i,
  output ifq_entry_t               head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  ifq_entry_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop_i && (count_q != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    push_ok = push_i && ((count_q != CntW'(Depth)) || pop_ok);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    count_o = count_q;
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetcher feeding a small decode queue.
// Issues word reads at fetch_pc while the queue plus the one in-flight read
// fit in QDEPTH, pushes each response {instr, addr+4} one cycle later and
// presents the head to decode. A taken-branch redirect empties the queue,
// drops the in-flight response and restarts fetch at the target after one
// FLUSH cycle.
// Parameters: XLEN (address width, 16..64), QDEPTH (power of 2, >= 2),
//             RESET_PC (first fetch address).
// Ports:
//   clock, reset             - rising-edge clock, async active-low reset
//   imem_req, imem_addr      - read request and word-aligned byte address
//   imem_rdata               - read data, one cycle after imem_req
//   redirect_valid/_pc       - taken branch and its target
//   id_valid, id_ready       - head valid / decode accepts head
//   id_instr, id_pcplus4     - head instruction and its PC+4
// Build option: define IFQ_JUMP_PREDECODE_EN to follow J instructions as
// they are pushed (fetch_pc <- jump target, sequential in-flight read
// killed); a same-cycle redirect wins. Without it J words are not examined.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned     XLEN     = IFQ_XLEN_DEFAULT,
  parameter int unsigned     QDEPTH   = IFQ_QDEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFQ_RESET_PC_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pcplus4
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  ifq_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q;
  logic            kill_q, kill_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy;
  logic            push, pop;
  ifq_entry_t      push_entry, head_entry;

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StBoot;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = StFlush;
    end else begin
      unique case (state_q)
        StBoot:  state_d = StRun;
        StRun:   state_d = StRun;
        StFlush: state_d = StRun;
        default: state_d = StBoot;
      endcase
    end
  end

  always_comb begin
    // The in-flight read is counted so its response always has a free slot.
    occupancy = {1'b0, count} + (CntW + 1)'(inflight_q);
    imem_req  = (state_q == StRun) && (occupancy < (CntW + 1)'(QDEPTH)) && !redirect_valid;
    imem_addr = fetch_pc_q;
  end

  // ---------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------
  always_comb begin
    push               = inflight_q && !kill_q && !redirect_valid;
    pop                = id_valid && id_ready;
    push_entry.instr   = imem_rdata;
    // fetch_pc_q advanced by 4 when the read was issued, so it still holds
    // the responding address + 4 whenever a push is allowed.
    push_entry.pcplus4 = IFQ_XLEN_MAX'(fetch_pc_q);
  end

  ifq_fifo #(
    .Depth (QDEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .head_o  (head_entry),
    .count_o (count)
  );

  always_comb begin
    id_valid   = (count != '0);
    id_instr   = head_entry.instr;
    id_pcplus4 = head_entry.pcplus4[XLEN-1:0];
  end

  if (XLEN < IFQ_XLEN_MAX) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^head_entry.pcplus4[IFQ_XLEN_MAX-1:XLEN];
  end

  // ---------------------------------------------------------------------
  // Jump predecode
  // ---------------------------------------------------------------------
`ifdef IFQ_JUMP_PREDECODE_EN
  logic            jump_hit;
  logic [XLEN-1:0] jump_target;

  assign jump_hit = push && (imem_rdata[31:26] == OP_J);

  if (XLEN > 28) begin : g_jt_wide
    assign jump_target = {fetch_pc_q[XLEN-1:28], imem_rdata[25:0], 2'b00};
  end else begin : g_jt_narrow
    assign jump_target = XLEN'({imem_rdata[25:0], 2'b00});
  end
`endif

  // ---------------------------------------------------------------------
  // Fetch PC and in-flight tracking
  // ---------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    kill_d     = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
    end else begin
      if (imem_req) fetch_pc_d = fetch_pc_q + XLEN'(4);
`ifdef IFQ_JUMP_PREDECODE_EN
      // The sequential read issued this cycle is dropped when it returns.
      if (jump_hit) begin
        fetch_pc_d = jump_target;
        kill_d     = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= imem_req;
      kill_q     <= kill_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned QDEPTH = 4;
  localparam logic [31:0] J_WORD = 32'h0800_0040;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pcplus4;

  ifetch_queue #(
    .XLEN     (XLEN),
    .QDEPTH   (QDEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pcplus4     (id_pcplus4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: decode queue as a SV queue, plus the one outstanding read.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        m_q[$];
  int          m_st;        // 0 boot, 1 run, 2 flush
  logic [31:0] m_fetch_pc;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_pend_killed;
  bit          j_armed;

  // Last observed DUT values, for directed checks.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (j_armed && a == 32'h0) return J_WORD;
    return {6'h33, a[27:2] ^ 26'h15A_5A5};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_st          = 0;
    m_fetch_pc    = 32'h0;
    m_pend        = 0;
    m_pend_addr   = 32'h0;
    m_pend_killed = 0;
  endtask

  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] rd;
    bit          exp_req, exp_valid, do_pop, do_push, nxt_killed;
    logic [31:0] issue_addr;
    ent_t        e;
    @(negedge clock);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    rd             = m_pend ? mem_word(m_pend_addr) : $urandom();
    imem_rdata     = rd;
    #1;
    exp_req   = (m_st == 1) && ((m_q.size() + int'(m_pend)) < QDEPTH) && !rv;
    exp_valid = (m_q.size() != 0);
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, m_fetch_pc);
    check_eq("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check_eq("id_instr", id_instr, m_q[0].instr);
      check_eq("id_pcplus4", id_pcplus4, m_q[0].pc4);
    end
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = id_valid;
    s_pc4   = id_pcplus4;

    do_pop     = exp_valid && rdy;
    do_push    = m_pend && !m_pend_killed && !rv;
    e.instr    = rd;
    e.pc4      = m_pend_addr + 32'd4;
    issue_addr = m_fetch_pc;
    nxt_killed = 0;
    if (rv) begin
      m_q.delete();
      m_fetch_pc = rpc & ~32'd3;
      m_st       = 2;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(e);
      if (exp_req) m_fetch_pc = m_fetch_pc + 32'd4;
`ifdef IFQ_JUMP_PREDECODE_EN
      if (do_push && rd[31:26] == 6'b000010) begin
        m_fetch_pc = {e.pc4[31:28], rd[25:0], 2'b00};
        nxt_killed = exp_req;
      end
`endif
      m_st = 1;
    end
    m_pend        = exp_req;
    m_pend_addr   = issue_addr;
    m_pend_killed = nxt_killed;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
    check_eq({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
    check_eq({tag, "_id_instr"}, id_instr, 32'd0);
    check_eq({tag, "_id_pcplus4"}, id_pcplus4, 32'd0);
    check_eq({tag, "_imem_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    int issues;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    imem_rdata     = 32'h0;
    j_armed        = 0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(posedge clock);
    #2 reset = 1'b1;

    // Reset release: BOOT, then 0x0, 0x4, 0x8; first head two cycles after issue.
    step(0, 0, 1);
    check_eq("boot_req", {31'b0, s_req}, 32'd0);
    step(0, 0, 1);
    check_eq("s1_req0", {31'b0, s_req}, 32'd1);
    check_eq("s1_addr0", s_addr, 32'h0);
    step(0, 0, 1);
    check_eq("s1_addr1", s_addr, 32'h4);
    check_eq("s1_valid_early", {31'b0, s_valid}, 32'd0);
    step(0, 0, 1);
    check_eq("s1_addr2", s_addr, 32'h8);
    check_eq("s1_valid", {31'b0, s_valid}, 32'd1);
    check_eq("s1_pc4", s_pc4, 32'h4);

    // Backpressure: empty queue, id_ready low -> exactly QDEPTH issues.
    step(1, 32'h200, 0);
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      if (s_req) issues++;
    end
    check_eq("s2_issues", issues, QDEPTH);
    check_eq("s2_stalled", {31'b0, s_req}, 32'd0);
    issues = 0;
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      if (s_req) issues++;
    end
    check_eq("s2_one_more", issues, 1);

    // Redirect with 3 queued entries and a response in flight.
    step(0, 0, 1);
    step(0, 0, 0);
    check_eq("s3_issue_before", {31'b0, s_req}, 32'd1);
    step(1, 32'h100, 0);
    check_eq("s3_valid_at_rdr", {31'b0, s_valid}, 32'd1);
    step(0, 0, 0);
    check_eq("s3_flush_valid", {31'b0, s_valid}, 32'd0);
    check_eq("s3_flush_req", {31'b0, s_req}, 32'd0);
    step(0, 0, 0);
    check_eq("s3_restart_req", {31'b0, s_req}, 32'd1);
    check_eq("s3_restart_addr", s_addr, 32'h100);

    // Redirect coinciding with a pop and a push.
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(1, 32'h302, 1);
    check_eq("s4_valid_at_rdr", {31'b0, s_valid}, 32'd1);
    step(0, 0, 1);
    check_eq("s4_emptied", {31'b0, s_valid}, 32'd0);
    step(0, 0, 1);
    check_eq("s4_addr", s_addr, 32'h300);
    step(0, 0, 1);
    step(0, 0, 1);
    check_eq("s4_first_pc4", s_pc4, 32'h304);

    // J word at 0x0.
    j_armed = 1;
    step(1, 32'h0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check_eq("s5_addr0", s_addr, 32'h0);
    step(0, 0, 1);
    check_eq("s5_addr1", s_addr, 32'h4);
    step(0, 0, 1);
`ifdef IFQ_JUMP_PREDECODE_EN
    check_eq("s5_addr_next", s_addr, 32'h100);
`else
    check_eq("s5_addr_next", s_addr, 32'h8);
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    j_armed = 0;

    // Address wrap.
    step(1, 32'hFFFF_FFFC, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check_eq("s6_addr_top", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 1);
    check_eq("s6_addr_wrap", s_addr, 32'h0);
    step(0, 0, 1);
    check_eq("s6_pc4_wrap", s_pc4, 32'h0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 11) == 0, $urandom(), $urandom_range(0, 3) != 0);

    // Reset mid-operation clears everything at once.
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    #2;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    reset          = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 15) == 0, $urandom(), $urandom_range(0, 1) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
